// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between two MEM-stage lanes, oldest lane first.
// Optional stuck-access watchdog is compiled in when DMEM_ARBITER_TIMEOUT_EN is defined.

`ifndef MEM_OP_BITS
`define MEM_OP_BITS 3
`endif
`ifndef MEM_OP_STORE_BIT
`define MEM_OP_STORE_BIT 2
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC     5'b00001
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID  5'b00010
`endif
`ifndef PIPE_REG_ID_EX
`define PIPE_REG_ID_EX  5'b00100
`endif
`ifndef PIPE_REG_EX_MEM
`define PIPE_REG_EX_MEM 5'b01000
`endif
`ifndef PIPE_REG_MEM_WB
`define PIPE_REG_MEM_WB 5'b10000
`endif

module dmem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0,
    input  logic                       req1,
    input  logic [`MEM_OP_BITS-1:0]    op0,
    input  logic [`MEM_OP_BITS-1:0]    op1,
    input  logic [DATA_WIDTH-1:0]      addr0,
    input  logic [DATA_WIDTH-1:0]      addr1,
    input  logic [DATA_WIDTH-1:0]      wdata0,
    input  logic [DATA_WIDTH-1:0]      wdata1,
    input  logic                       first,
    output logic                       mem_valid,
    output logic [`MEM_OP_BITS-1:0]    mem_op,
    output logic [DATA_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ready,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [DATA_WIDTH-1:0]      rdata0,
    output logic [DATA_WIDTH-1:0]      rdata1,
    output logic                       done0,
    output logic                       done1,
    output logic [`NUM_PIPE_MASKS-1:0] stall0,
    output logic [`NUM_PIPE_MASKS-1:0] stall1,
    output logic [`NUM_PIPE_MASKS-1:0] flush0,
    output logic [`NUM_PIPE_MASKS-1:0] flush1,
    output logic                       err
);

    localparam logic [`NUM_PIPE_MASKS-1:0] STALL_MASK =
        `PIPE_REG_PC | `PIPE_REG_IF_ID | `PIPE_REG_ID_EX | `PIPE_REG_EX_MEM;
    localparam logic [`NUM_PIPE_MASKS-1:0] FLUSH_MASK = `PIPE_REG_MEM_WB;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      served0;
    logic                      served1;
    logic                      winner;
    logic [`MEM_OP_BITS-1:0]   lat_op;
    logic [DATA_WIDTH-1:0]     lat_addr;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic                      pend0;
    logic                      pend1;
    logic                      any_pend;
    logic                      grant1;
    logic                      mem_ok;
    logic                      timed_out;
    logic                      complete;
    logic [DATA_WIDTH-1:0]     load_value;

    assign pend0    = req0 & ~served0;
    assign pend1    = req1 & ~served1;
    assign any_pend = pend0 | pend1;
    // Lane 1 wins when it is the only one waiting, or when both wait and it is older.
    assign grant1   = pend1 & (~pend0 | first);

    assign mem_ok     = (state == BUSY) && mem_ready;
    assign complete   = mem_ok || timed_out;
    assign load_value = timed_out ? '0 : mem_rdata;

`ifdef DMEM_ARBITER_TIMEOUT_EN
    logic [7:0] to_count;

    assign timed_out = (state == BUSY) && !mem_ready &&
                       (to_count == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_count <= '0;
        end else if (state == IDLE && any_pend) begin
            to_count <= '0;
        end else if (state == BUSY && !mem_ready) begin
            to_count <= to_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (timed_out) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timed_out          = 1'b0;
    assign err                = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_valid  = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        stall0     = '0;
        stall1     = '0;
        flush0     = '0;
        flush1     = '0;

        case (state)
            IDLE: begin
                if (any_pend) state_next = BUSY;
            end
            BUSY: begin
                mem_valid = 1'b1;
                if (complete) state_next = DONE;
            end
            DONE: begin
                done0      = ~winner;
                done1      = winner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (any_pend) begin
            stall0 = STALL_MASK;
            stall1 = STALL_MASK;
            flush0 = FLUSH_MASK;
            flush1 = FLUSH_MASK;
        end
    end

    assign mem_op    = lat_op;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // Request fields are frozen at grant so the memory sees a stable request for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            winner    <= 1'b0;
            lat_op    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && any_pend) begin
            winner    <= grant1;
            lat_op    <= grant1 ? op1 : op0;
            lat_addr  <= grant1 ? addr1 : addr0;
            lat_wdata <= grant1 ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            served0 <= 1'b0;
            served1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            // Nothing pending means the pipeline advances, so the served marks start over.
            if (!any_pend) begin
                served0 <= 1'b0;
                served1 <= 1'b0;
            end else if (complete) begin
                if (winner) served1 <= 1'b1;
                else        served0 <= 1'b1;
            end

            if (complete && (timed_out || !lat_op[`MEM_OP_STORE_BIT])) begin
                if (winner) rdata1 <= load_value;
                else        rdata0 <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios with a queue-based scoreboard for memory requests and done pulses.
// Expects TIMEOUT_CYCLES=4 behaviour when DMEM_ARBITER_TIMEOUT_EN is defined.

`ifndef MEM_OP_BITS
`define MEM_OP_BITS 3
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif

module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int TO = 4;
    localparam logic [2:0] OP_LW = 3'b010;
    localparam logic [2:0] OP_SW = 3'b110;
    localparam logic [4:0] STALL_EXP = 5'b01111;
    localparam logic [4:0] FLUSH_EXP = 5'b10000;

    typedef struct packed {
        logic [2:0]    op;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic          lane;
        logic [DW-1:0] data;
    } done_exp_t;

    logic                       clk;
    logic                       reset;
    logic                       req0, req1, first;
    logic [`MEM_OP_BITS-1:0]    op0, op1;
    logic [DW-1:0]              addr0, addr1, wdata0, wdata1;
    logic                       mem_valid;
    logic [`MEM_OP_BITS-1:0]    mem_op;
    logic [DW-1:0]              mem_addr, mem_wdata;
    logic                       mem_ready;
    logic [DW-1:0]              mem_rdata;
    logic [DW-1:0]              rdata0, rdata1;
    logic                       done0, done1;
    logic [`NUM_PIPE_MASKS-1:0] stall0, stall1, flush0, flush1;
    logic                       err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    mem_exp_t  cur_mem;
    done_exp_t cur_done;
    logic      prev_valid = 1'b0;

    dmem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .first(first),
        .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
        .stall0(stall0), .stall1(stall1), .flush0(flush0), .flush1(flush1),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic fst,
                                 input logic [2:0] o0, input logic [2:0] o1,
                                 input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                 input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        req0 = r0; req1 = r1; first = fst;
        op0 = o0; op1 = o1;
        addr0 = a0; addr1 = a1;
        wdata0 = w0; wdata1 = w1;
    endtask

    task automatic memResp(input logic rdy, input logic [DW-1:0] data);
        mem_ready = rdy;
        mem_rdata = data;
    endtask

    // Checks one cycle's handshake, masks and done pulses, then moves to just after the next edge.
    task automatic cyc(input string tag, input logic exp_valid, input logic exp_pend,
                       input logic exp_d0, input logic exp_d1);
        @(negedge clk);
        checkOutput({tag, ".mem_valid"}, mem_valid, exp_valid);
        checkOutput({tag, ".stall0"}, stall0, exp_pend ? STALL_EXP : 5'b0);
        checkOutput({tag, ".stall1"}, stall1, exp_pend ? STALL_EXP : 5'b0);
        checkOutput({tag, ".flush0"}, flush0, exp_pend ? FLUSH_EXP : 5'b0);
        checkOutput({tag, ".flush1"}, flush1, exp_pend ? FLUSH_EXP : 5'b0);
        checkOutput({tag, ".done0"}, done0, exp_d0);
        checkOutput({tag, ".done1"}, done1, exp_d1);
        @(posedge clk);
        #1;
    endtask

    task automatic idleLanes();
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LW, OP_LW, '0, '0, '0, '0);
    endtask

    // Scoreboard monitor: request fields on every valid cycle, read data on every done pulse.
    always @(negedge clk) begin
        if (mem_valid === 1'b1) begin
            if (prev_valid !== 1'b1) begin
                if (mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_mem_req: got addr 0x%0h, expected no request", mem_addr);
                    cur_mem = {mem_op, mem_addr, mem_wdata};
                end else begin
                    cur_mem = mem_q.pop_front();
                end
            end
            checkOutput("mem_req", {mem_op, mem_addr, mem_wdata}, cur_mem);
        end
        prev_valid = mem_valid;

        if (done0 === 1'b1 || done1 === 1'b1) begin
            checkOutput("done_onehot", done0 & done1, 1'b0);
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got done0=%0b done1=%0b, expected none", done0, done1);
            end else begin
                cur_done = done_q.pop_front();
                checkOutput("done_lane", done1, cur_done.lane);
                checkOutput("done_rdata", cur_done.lane ? rdata1 : rdata0, cur_done.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idleLanes();
        memResp(1'b0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst.mem_valid", mem_valid, 1'b0);
        checkOutput("rst.done", {done0, done1}, 2'b00);
        checkOutput("rst.rdata0", rdata0, 32'h0);
        checkOutput("rst.rdata1", rdata1, 32'h0);
        checkOutput("rst.err", err, 1'b0);
        checkOutput("rst.stall0", stall0, 5'b0);
        @(posedge clk);
        #1;

        // Single lane-0 load, memory always ready.
        applyStimulus(1'b1, 1'b0, 1'b0, OP_LW, OP_LW, 32'h40, 32'h0, 32'h0, 32'h0);
        memResp(1'b1, 32'hDEADBEEF);
        mem_q.push_back('{OP_LW, 32'h40, 32'h0});
        done_q.push_back('{1'b0, 32'hDEADBEEF});
        cyc("a0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("a1", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("a2", 1'b0, 1'b0, 1'b1, 1'b0);
        idleLanes();
        cyc("a3", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("a.rdata0", rdata0, 32'hDEADBEEF);
        checkOutput("a.err", err, 1'b0);

        // Both lanes, lane 1 older.
        applyStimulus(1'b1, 1'b1, 1'b1, OP_LW, OP_LW, 32'h20, 32'h10, 32'h0, 32'h0);
        memResp(1'b1, 32'hA1A10001);
        mem_q.push_back('{OP_LW, 32'h10, 32'h0});
        mem_q.push_back('{OP_LW, 32'h20, 32'h0});
        done_q.push_back('{1'b1, 32'hA1A10001});
        done_q.push_back('{1'b0, 32'hB2B20002});
        cyc("b0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("b1", 1'b1, 1'b1, 1'b0, 1'b0);
        memResp(1'b1, 32'hB2B20002);
        cyc("b2", 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("b3", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("b4", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("b5", 1'b0, 1'b0, 1'b1, 1'b0);
        idleLanes();
        cyc("b6", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b.rdata1", rdata1, 32'hA1A10001);
        checkOutput("b.rdata0", rdata0, 32'hB2B20002);

        // Both lanes, lane 0 older; lane 1 is a store that must not touch rdata1.
        applyStimulus(1'b1, 1'b1, 1'b0, OP_LW, OP_SW, 32'h30, 32'h34, 32'h99, 32'h77);
        memResp(1'b1, 32'hC0C00003);
        mem_q.push_back('{OP_LW, 32'h30, 32'h99});
        mem_q.push_back('{OP_SW, 32'h34, 32'h77});
        done_q.push_back('{1'b0, 32'hC0C00003});
        done_q.push_back('{1'b1, 32'hA1A10001});
        cyc("c0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("c1", 1'b1, 1'b1, 1'b0, 1'b0);
        memResp(1'b1, 32'hD0D00004);
        cyc("c2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("c3", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("c4", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("c5", 1'b0, 1'b0, 1'b0, 1'b1);
        idleLanes();
        cyc("c6", 1'b0, 1'b0, 1'b0, 1'b0);

        // Lane-1 store with memory stalling three cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, OP_LW, OP_SW, 32'h0, 32'h80, 32'h0, 32'h1234);
        memResp(1'b0, 32'h55555555);
        mem_q.push_back('{OP_SW, 32'h80, 32'h1234});
        done_q.push_back('{1'b1, 32'hA1A10001});
        cyc("d0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("d1", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("d2", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("d3", 1'b1, 1'b1, 1'b0, 1'b0);
        memResp(1'b1, 32'h55555555);
        cyc("d4", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("d5", 1'b0, 1'b0, 1'b0, 1'b1);
        idleLanes();
        memResp(1'b0, 32'h0);
        cyc("d6", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("d.rdata1", rdata1, 32'hA1A10001);

        // Reset in the second BUSY cycle abandons the access.
        applyStimulus(1'b1, 1'b0, 1'b0, OP_LW, OP_LW, 32'h44, 32'h0, 32'h0, 32'h0);
        memResp(1'b0, 32'hEEEEEEEE);
        mem_q.push_back('{OP_LW, 32'h44, 32'h0});
        cyc("e0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("e1", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc("e2", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        idleLanes();
        memResp(1'b1, 32'hEEEEEEEE);
        cyc("e3", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("e4", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("e.rdata0", rdata0, 32'h0);
        checkOutput("e.rdata1", rdata1, 32'h0);

        // Fresh load so the timeout case has a nonzero rdata0 to overwrite.
        applyStimulus(1'b1, 1'b0, 1'b0, OP_LW, OP_LW, 32'h50, 32'h0, 32'h0, 32'h0);
        memResp(1'b1, 32'hCAFEF00D);
        mem_q.push_back('{OP_LW, 32'h50, 32'h0});
        done_q.push_back('{1'b0, 32'hCAFEF00D});
        cyc("f0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("f1", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("f2", 1'b0, 1'b0, 1'b1, 1'b0);
        idleLanes();
        cyc("f3", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("f.rdata0", rdata0, 32'hCAFEF00D);

        // Memory never answers.
        applyStimulus(1'b1, 1'b0, 1'b0, OP_LW, OP_LW, 32'h60, 32'h0, 32'h0, 32'h0);
        memResp(1'b0, 32'h0BADCAFE);
        mem_q.push_back('{OP_LW, 32'h60, 32'h0});
`ifdef DMEM_ARBITER_TIMEOUT_EN
        done_q.push_back('{1'b0, 32'h0});
        cyc("g0", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            checkOutput("g.err_before", err, 1'b0);
            cyc("g.busy", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        cyc("g.done", 1'b0, 1'b0, 1'b1, 1'b0);
        idleLanes();
        cyc("g.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("g.err", err, 1'b1);
        checkOutput("g.rdata0", rdata0, 32'h0);
`else
        done_q.push_back('{1'b0, 32'h0BADCAFE});
        cyc("g0", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc("g.busy", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("g.err", err, 1'b0);
        memResp(1'b1, 32'h0BADCAFE);
        cyc("g.last", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("g.done", 1'b0, 1'b0, 1'b1, 1'b0);
        idleLanes();
        memResp(1'b0, 32'h0);
        cyc("g.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("g.rdata0", rdata0, 32'h0BADCAFE);
        checkOutput("g.err_after", err, 1'b0);
`endif

        checkOutput("mem_q_left", mem_q.size(), 0);
        checkOutput("done_q_left", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
